// File: rtl/pwm_regs_mc.sv
// Multi-channel PWM register block: shadowed period/compare with commit on
// counter wrap or while disabled, direct control registers, W1C overflow
// flags, masked level interrupt and registered read-back.
module pwm_regs_mc #(
  parameter int unsigned NCH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [7:0]        addr,
  input  logic [7:0]        data_write,
  output logic [7:0]        data_read,
  input  logic [NCH*16-1:0] counter_val,
  input  logic [NCH-1:0]    ovf,
  output logic [NCH*16-1:0] period,
  output logic [NCH*16-1:0] compare1,
  output logic [NCH*16-1:0] compare2,
  output logic [NCH*8-1:0]  prescale,
  output logic [NCH*8-1:0]  functions,
  output logic [NCH-1:0]    en,
  output logic [NCH-1:0]    upnotdown,
  output logic [NCH-1:0]    pwm_en,
  output logic [NCH-1:0]    count_reset,
  output logic              irq
);

  localparam logic [3:0] R_PER_LO = 4'h0;
  localparam logic [3:0] R_PER_HI = 4'h1;
  localparam logic [3:0] R_EN     = 4'h2;
  localparam logic [3:0] R_C1_LO  = 4'h3;
  localparam logic [3:0] R_C1_HI  = 4'h4;
  localparam logic [3:0] R_C2_LO  = 4'h5;
  localparam logic [3:0] R_C2_HI  = 4'h6;
  localparam logic [3:0] R_CRST   = 4'h7;
  localparam logic [3:0] R_CNT_LO = 4'h8;
  localparam logic [3:0] R_CNT_HI = 4'h9;
  localparam logic [3:0] R_PRE    = 4'hA;
  localparam logic [3:0] R_UND    = 4'hB;
  localparam logic [3:0] R_PEN    = 4'hC;
  localparam logic [3:0] R_FN     = 4'hD;
  localparam logic [3:0] R_STAT   = 4'hE;
  localparam logic [7:0] A_MASK   = 8'hF0;
  localparam logic [7:0] A_ISTAT  = 8'hF1;

  logic [3:0]     page;
  logic [3:0]     reg_sel;
  logic [NCH-1:0] flag_v;
  logic [NCH-1:0] irq_mask;
  logic [7:0]     rd_ch [NCH];
  logic [7:0]     rd_c;

  assign page    = addr[7:4];
  assign reg_sel = addr[3:0];

  for (genvar c = 0; c < NCH; c++) begin : gen_ch
    localparam logic [3:0] CH = 4'(c);

    logic [15:0] per_sh, c1_sh, c2_sh, per_q, c1_q, c2_q;
    logic [7:0]  pre_q, fn_q;
    logic        en_q, und_q, pen_q, crst_q, flag_q, pend_q, auto_q;
    logic        sel, sh_wr, commit, en_set;

    assign sel    = write && (page == CH);
    assign sh_wr  = sel && (reg_sel inside {R_PER_LO, R_PER_HI, R_C1_LO,
                                            R_C1_HI, R_C2_LO, R_C2_HI});
    assign en_set = sel && (reg_sel == R_EN) && data_write[0];
    assign commit = auto_q || (pend_q && (ovf[c] || en_set));

    // Channel register state; commit copies old shadow before any same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        per_sh <= '0; c1_sh <= '0; c2_sh <= '0;
        per_q  <= '0; c1_q  <= '0; c2_q  <= '0;
        pre_q  <= '0; fn_q  <= '0;
        en_q   <= 1'b0; und_q <= 1'b0; pen_q <= 1'b0;
        crst_q <= 1'b0; flag_q <= 1'b0; pend_q <= 1'b0; auto_q <= 1'b0;
      end else begin
        if (commit) begin
          per_q <= per_sh;
          c1_q  <= c1_sh;
          c2_q  <= c2_sh;
        end
        if (sel) begin
          case (reg_sel)
            R_PER_LO: per_sh[7:0]  <= data_write;
            R_PER_HI: per_sh[15:8] <= data_write;
            R_EN:     en_q         <= data_write[0];
            R_C1_LO:  c1_sh[7:0]   <= data_write;
            R_C1_HI:  c1_sh[15:8]  <= data_write;
            R_C2_LO:  c2_sh[7:0]   <= data_write;
            R_C2_HI:  c2_sh[15:8]  <= data_write;
            R_PRE:    pre_q        <= data_write;
            R_UND:    und_q        <= data_write[0];
            R_PEN:    pen_q        <= data_write[0];
            R_FN:     fn_q         <= data_write;
            default:  ;
          endcase
        end
        if (sh_wr)       pend_q <= 1'b1;
        else if (commit) pend_q <= 1'b0;
        auto_q <= sh_wr && !en_q;
        crst_q <= sel && (reg_sel == R_CRST);
        if (ovf[c])
          flag_q <= 1'b1;
        else if (sel && (reg_sel == R_STAT) && data_write[0])
          flag_q <= 1'b0;
      end
    end

    // Per-channel read-back; period/compare return the shadow copy
    always_comb begin
      rd_ch[c] = 8'h00;
      case (reg_sel)
        R_PER_LO: rd_ch[c] = per_sh[7:0];
        R_PER_HI: rd_ch[c] = per_sh[15:8];
        R_EN:     rd_ch[c] = {7'b0, en_q};
        R_C1_LO:  rd_ch[c] = c1_sh[7:0];
        R_C1_HI:  rd_ch[c] = c1_sh[15:8];
        R_C2_LO:  rd_ch[c] = c2_sh[7:0];
        R_C2_HI:  rd_ch[c] = c2_sh[15:8];
        R_CNT_LO: rd_ch[c] = counter_val[16*c +: 8];
        R_CNT_HI: rd_ch[c] = counter_val[16*c+8 +: 8];
        R_PRE:    rd_ch[c] = pre_q;
        R_UND:    rd_ch[c] = {7'b0, und_q};
        R_PEN:    rd_ch[c] = {7'b0, pen_q};
        R_FN:     rd_ch[c] = fn_q;
        R_STAT:   rd_ch[c] = {6'b0, pend_q, flag_q};
        default:  rd_ch[c] = 8'h00;
      endcase
    end

    assign period[16*c +: 16]   = per_q;
    assign compare1[16*c +: 16] = c1_q;
    assign compare2[16*c +: 16] = c2_q;
    assign prescale[8*c +: 8]   = pre_q;
    assign functions[8*c +: 8]  = fn_q;
    assign en[c]                = en_q;
    assign upnotdown[c]         = und_q;
    assign pwm_en[c]            = pen_q;
    assign count_reset[c]       = crst_q;
    assign flag_v[c]            = flag_q;
  end

  // Global read mux; channels beyond NCH and unmapped addresses read zero
  always_comb begin
    rd_c = 8'h00;
    if (addr == A_MASK) begin
      rd_c = 8'(irq_mask);
    end else if (addr == A_ISTAT) begin
      rd_c = 8'(flag_v & irq_mask);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (page == 4'(i)) rd_c = rd_ch[i];
      end
    end
  end

  // Interrupt mask, registered interrupt level and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_mask  <= '0;
      irq       <= 1'b0;
      data_read <= 8'h00;
    end else begin
      if (write && (addr == A_MASK)) irq_mask <= data_write[NCH-1:0];
      irq <= |(flag_v & irq_mask);
      if (read) data_read <= rd_c;
    end
  end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// Self-checking bench for pwm_regs_mc: directed scenarios followed by random
// register traffic, all compared against a behavioural register-map model.
module tb_pwm_regs_mc;
  localparam int unsigned NCH = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              read, write;
  logic [7:0]        addr, data_write, data_read;
  logic [NCH*16-1:0] counter_val;
  logic [NCH-1:0]    ovf;
  logic [NCH*16-1:0] period, compare1, compare2;
  logic [NCH*8-1:0]  prescale, functions;
  logic [NCH-1:0]    en, upnotdown, pwm_en, count_reset;
  logic              irq;

  int total = 0;
  int bad   = 0;

  pwm_regs_mc #(.NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read), .counter_val(counter_val),
    .ovf(ovf), .period(period), .compare1(compare1), .compare2(compare2),
    .prescale(prescale), .functions(functions), .en(en), .upnotdown(upnotdown),
    .pwm_en(pwm_en), .count_reset(count_reset), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  int unsigned m_psh[NCH], m_c1sh[NCH], m_c2sh[NCH];
  int unsigned m_per[NCH], m_c1[NCH], m_c2[NCH], m_pre[NCH], m_fn[NCH];
  bit m_en[NCH], m_und[NCH], m_pen[NCH], m_crst[NCH], m_flag[NCH];
  bit m_pend[NCH], m_after_wr_dis[NCH];
  bit [7:0] m_mask, m_rd;
  bit m_irq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_psh[c] = 0; m_c1sh[c] = 0; m_c2sh[c] = 0;
      m_per[c] = 0; m_c1[c] = 0; m_c2[c] = 0; m_pre[c] = 0; m_fn[c] = 0;
      m_en[c] = 0; m_und[c] = 0; m_pen[c] = 0; m_crst[c] = 0; m_flag[c] = 0;
      m_pend[c] = 0; m_after_wr_dis[c] = 0;
    end
    m_mask = 0; m_rd = 0; m_irq = 0;
  endtask

  function automatic int unsigned set_byte(int unsigned v, bit hi, bit [7:0] d);
    if (hi) return (v % 256) + 256 * d;
    return (v / 256) * 256 + d;
  endfunction

  function automatic bit [7:0] flags();
    bit [7:0] f = 0;
    for (int c = 0; c < NCH; c++) f[c] = m_flag[c];
    return f;
  endfunction

  function automatic bit [7:0] model_read(input bit [7:0] a);
    int ch = int'(a[7:4]);
    int rg = int'(a[3:0]);
    bit [15:0] cnt;
    if (a == 8'hF0) return m_mask;
    if (a == 8'hF1) return flags() & m_mask;
    if (ch >= NCH) return 0;
    cnt = counter_val[16*ch +: 16];
    case (rg)
      0: return 8'(m_psh[ch] % 256);   1: return 8'(m_psh[ch] / 256);
      2: return {7'b0, m_en[ch]};
      3: return 8'(m_c1sh[ch] % 256);  4: return 8'(m_c1sh[ch] / 256);
      5: return 8'(m_c2sh[ch] % 256);  6: return 8'(m_c2sh[ch] / 256);
      8: return cnt[7:0];              9: return cnt[15:8];
      10: return 8'(m_pre[ch]);
      11: return {7'b0, m_und[ch]};
      12: return {7'b0, m_pen[ch]};
      13: return 8'(m_fn[ch]);
      14: return {6'b0, m_pend[ch], m_flag[ch]};
      default: return 0;
    endcase
  endfunction

  // Advance the model across one rising edge given the inputs of that cycle
  task automatic model_edge(input bit r, input bit w, input bit [7:0] a,
                            input bit [7:0] d, input bit [NCH-1:0] o);
    int ch = int'(a[7:4]);
    int rg = int'(a[3:0]);
    bit hit, cm, sw, en_old;
    if (r) m_rd = model_read(a);
    m_irq = |(flags() & m_mask);
    if (w && a == 8'hF0) m_mask = d & 8'((1 << NCH) - 1);
    for (int c = 0; c < NCH; c++) begin
      hit = w && (ch == c);
      en_old = m_en[c];
      cm = m_after_wr_dis[c] || (m_pend[c] && (o[c] || (hit && rg == 2 && d[0])));
      if (cm) begin m_per[c] = m_psh[c]; m_c1[c] = m_c1sh[c]; m_c2[c] = m_c2sh[c]; end
      sw = hit && (rg inside {0, 1, 3, 4, 5, 6});
      if (hit) begin
        case (rg)
          0, 1: m_psh[c]  = set_byte(m_psh[c], rg == 1, d);
          3, 4: m_c1sh[c] = set_byte(m_c1sh[c], rg == 4, d);
          5, 6: m_c2sh[c] = set_byte(m_c2sh[c], rg == 6, d);
          2: m_en[c] = d[0];
          10: m_pre[c] = d;
          11: m_und[c] = d[0];
          12: m_pen[c] = d[0];
          13: m_fn[c] = d;
          default: ;
        endcase
      end
      m_pend[c] = sw ? 1'b1 : (cm ? 1'b0 : m_pend[c]);
      m_after_wr_dis[c] = sw && !en_old;
      m_crst[c] = hit && rg == 7;
      if (o[c]) m_flag[c] = 1;
      else if (hit && rg == 14 && d[0]) m_flag[c] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] ep = 0, e1 = 0, e2 = 0, epr = 0, efn = 0;
    logic [63:0] een = 0, eud = 0, epe = 0, ecr = 0;
    for (int c = 0; c < NCH; c++) begin
      ep[16*c +: 16] = 16'(m_per[c]); e1[16*c +: 16] = 16'(m_c1[c]);
      e2[16*c +: 16] = 16'(m_c2[c]);
      epr[8*c +: 8] = 8'(m_pre[c]); efn[8*c +: 8] = 8'(m_fn[c]);
      een[c] = m_en[c]; eud[c] = m_und[c]; epe[c] = m_pen[c]; ecr[c] = m_crst[c];
    end
    chk({tag, ".period"}, 64'(period), ep);
    chk({tag, ".compare1"}, 64'(compare1), e1);
    chk({tag, ".compare2"}, 64'(compare2), e2);
    chk({tag, ".prescale"}, 64'(prescale), epr);
    chk({tag, ".functions"}, 64'(functions), efn);
    chk({tag, ".en"}, 64'(en), een);
    chk({tag, ".upnotdown"}, 64'(upnotdown), eud);
    chk({tag, ".pwm_en"}, 64'(pwm_en), epe);
    chk({tag, ".count_reset"}, 64'(count_reset), ecr);
    chk({tag, ".irq"}, 64'(irq), 64'(m_irq));
    chk({tag, ".data_read"}, 64'(data_read), 64'(m_rd));
  endtask

  // One clock: drive inputs, advance model, clock, compare just after the edge
  task automatic cyc(input string tag, input bit r, input bit w, input bit [7:0] a,
                     input bit [7:0] d, input bit [NCH-1:0] o);
    read = r; write = w; addr = a; data_write = d; ovf = o;
    model_edge(r, w, a, d, o);
    @(posedge clk); #1;
    read = 0; write = 0; ovf = '0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 0; #1;
    model_reset();
    check_all(tag);
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    rst_n = 1; read = 0; write = 0; addr = 0; data_write = 0; ovf = '0;
    counter_val = '0;
    #2;
    do_reset("reset");

    // Shadowed period on an enabled channel, committed by overflow
    cyc("en0", 0, 1, 8'h02, 8'h01, 2'b00);
    cyc("per_lo", 0, 1, 8'h00, 8'h34, 2'b00);
    cyc("per_hi", 0, 1, 8'h01, 8'h12, 2'b00);
    chk("per_held", 64'(period[15:0]), 64'h0);
    cyc("stat_rd", 1, 0, 8'h0E, 8'h00, 2'b00);
    chk("pend_set", 64'(data_read[1]), 64'h1);
    cyc("ovf0", 0, 0, 8'h00, 8'h00, 2'b01);
    chk("per_commit", 64'(period[15:0]), 64'h1234);
    cyc("stat_rd2", 1, 0, 8'h0E, 8'h00, 2'b00);
    chk("pend_clr", 64'(data_read[1]), 64'h0);

    // Disabled channel commits on the cycle after the shadow write
    cyc("c1_wr", 0, 1, 8'h13, 8'h80, 2'b00);
    cyc("c1_idle", 0, 0, 8'h00, 8'h00, 2'b00);
    chk("c1_commit", 64'(compare1[31:16]), 64'h0080);

    // Interrupt: set beats clear, clear alone drops irq
    cyc("mask", 0, 1, 8'hF0, 8'h01, 2'b00);
    cyc("ovf_a", 0, 0, 8'h00, 8'h00, 2'b01);
    cyc("irq_up", 0, 0, 8'h00, 8'h00, 2'b00);
    chk("irq_set", 64'(irq), 64'h1);
    cyc("clr_ovf", 0, 1, 8'h0E, 8'h01, 2'b01);
    cyc("flag_rd", 1, 0, 8'h0E, 8'h00, 2'b00);
    chk("flag_kept", 64'(data_read[0]), 64'h1);
    cyc("clr", 0, 1, 8'h0E, 8'h01, 2'b00);
    cyc("irq_dn", 0, 0, 8'h00, 8'h00, 2'b00);
    chk("irq_clr", 64'(irq), 64'h0);

    // Back-to-back count_reset pulses on channel 1 only
    cyc("crst_a", 0, 1, 8'h17, 8'h00, 2'b00);
    chk("crst_p1", 64'(count_reset), 64'h2);
    cyc("crst_b", 0, 1, 8'h17, 8'h00, 2'b00);
    chk("crst_p2", 64'(count_reset), 64'h2);
    cyc("crst_end", 0, 0, 8'h00, 8'h00, 2'b00);
    chk("crst_off", 64'(count_reset), 64'h0);

    // Counter read-back
    counter_val = 32'h0000_BEEF;
    cyc("cnt_lo", 1, 0, 8'h08, 8'h00, 2'b00);
    chk("cnt_lo_val", 64'(data_read), 64'hEF);
    cyc("cnt_hi", 1, 0, 8'h09, 8'h00, 2'b00);
    chk("cnt_hi_val", 64'(data_read), 64'hBE);

    // Read+write same cycle returns the pre-write value; out-of-range channel
    cyc("rw", 1, 1, 8'h0A, 8'h5A, 2'b00);
    chk("rw_old", 64'(data_read), 64'h00);
    cyc("oor_wr", 0, 1, 8'h2A, 8'h77, 2'b00);
    cyc("oor_rd", 1, 0, 8'h2A, 8'h00, 2'b00);
    chk("oor_zero", 64'(data_read), 64'h00);

    // Reset with a pending update discards it
    cyc("pend_wr", 0, 1, 8'h00, 8'h55, 2'b00);
    do_reset("reset2");
    cyc("post_ovf", 0, 0, 8'h00, 8'h00, 2'b01);
    chk("no_commit", 64'(period[15:0]), 64'h0);
    cyc("post_stat", 1, 0, 8'h0E, 8'h00, 2'b00);
    chk("no_pend", 64'(data_read[1]), 64'h0);

    // Random register traffic
    for (int i = 0; i < 600; i++) begin
      bit [7:0] a;
      bit [3:0] pg;
      bit [NCH-1:0] o;
      int sel = $urandom_range(0, 9);
      pg = (sel == 0) ? 4'hF : 4'($urandom_range(0, NCH));
      a = {pg, 4'($urandom_range(0, 15))};
      if (pg == 4'hF) a[3:0] = 4'($urandom_range(0, 2));
      for (int c = 0; c < NCH; c++) o[c] = ($urandom_range(0, 7) == 0);
      counter_val = NCH*16'($urandom);
      cyc("rand", bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), a,
          8'($urandom), o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_regs_mc.md
PWM_REGS_MC -- requirements
Module: pwm_regs_mc

Interface
REQ-001 SHALL have parameter NCH, default 2, number of PWM channels (legal 1..8).
REQ-002 SHALL have clk input, width 1, the rising-edge clock for all state.
REQ-003 SHALL have rst_n input, width 1, asynchronous active-low reset.
REQ-004 SHALL have read input, width 1, the read strobe from the decoder.
REQ-005 SHALL have write input, width 1, the write strobe from the decoder.
REQ-006 SHALL have addr input, width 8: addr[7:4] is the channel, addr[3:0] is the register; page 0xF is global.
REQ-007 SHALL have data_write input, width 8, the write data.
REQ-008 SHALL have data_read output, width 8, the registered read data.
REQ-009 SHALL have counter_val input, width NCH*16, the channel counters (channel c at bits [16c+15:16c]).
REQ-010 SHALL have ovf input, width NCH, a 1-cycle per-channel counter period-wrap pulse.
REQ-011 SHALL have the following per-channel outputs, flattened: period (NCH*16), compare1 (NCH*16), compare2 (NCH*16), prescale (NCH*8), functions (NCH*8), en (NCH), upnotdown (NCH), pwm_en (NCH), count_reset (NCH).
REQ-012 SHALL have irq output, width 1, the level interrupt.

Function
REQ-013 Per-channel register map SHALL be:
- 0x0/0x1 period lo/hi
- 0x2 en[0]
- 0x3/0x4 compare1 lo/hi
- 0x5/0x6 compare2 lo/hi
- 0x7 count_reset (write-only)
- 0x8/0x9 counter lo/hi (read-only)
- 0xA prescale
- 0xB upnotdown[0]
- 0xC pwm_en[0]
- 0xD functions
- 0xE status: bit0 ovf_flag (W1C), bit1 upd_pending (read-only)
REQ-014 Global register map SHALL be: 0xF0 irq_mask[NCH-1:0] (R/W); 0xF1 irq_status = ovf_flag & irq_mask (read-only).
REQ-015 Writes to period, compare1 and compare2 SHALL land in shadow registers, set upd_pending, and leave the active outputs unchanged.
REQ-016 Commit SHALL copy all three shadow registers to the active registers in one cycle and clear upd_pending.
REQ-017 Commit SHALL occur on the cycle ovf[c]=1 while upd_pending[c]=1, or on the cycle after a shadow write when en[c]=0.
REQ-018 A shadow write in the same cycle as a commit SHALL update the shadow after the copy; active takes the old shadow and upd_pending stays 1.
REQ-019 Writing a 1 to en[c] SHALL force a commit in that cycle if upd_pending=1.
REQ-020 prescale, upnotdown, pwm_en and functions SHALL be written directly and take effect the next cycle.
REQ-021 A write to 0x7 SHALL pulse count_reset[c] for exactly 1 cycle; back-to-back writes SHALL give back-to-back pulses.
REQ-022 ovf_flag[c] SHALL set on ovf[c]=1 and clear on a write of data_write[0]=1 to 0xE; set SHALL win over clear in the same cycle.
REQ-023 irq SHALL be registered, equal to |(ovf_flag & irq_mask), and valid 1 cycle after a flag or mask change.
REQ-024 Reads SHALL have 1-cycle latency: data_read is sampled at the edge where read=1 and held until the next read; unmapped or read-only-zero addresses SHALL return 0x00.
REQ-025 read=1 and write=1 in the same cycle SHALL perform the write and return the pre-write value.
REQ-026 Reads of period/compare addresses SHALL return the shadow value, not the active value.
REQ-027 An address with channel >= NCH (other than page 0xF) SHALL have writes ignored and reads return 0x00.

Reset
REQ-028 On rst_n=0, all active, shadow, mask and flag registers, upd_pending, count_reset, irq and data_read SHALL asynchronously go to 0.
REQ-029 Reset mid-transaction SHALL discard any pending commit or pulse, with no output glitch after release.

Verification
REQ-030 ch0 en=1, write 0x00=0x34 and 0x01=0x12 -> period[15:0] stays 0 and status bit1=1; ovf[0] pulse -> period=0x1234 next cycle and bit1=0.
REQ-031 ch1 en=0, write compare1 lo=0x80 -> compare1[31:16]=0x0080 after 1 cycle with no ovf needed.
REQ-032 Set irq_mask=0x1, pulse ovf[0] -> irq=1; write 0x0E=0x01 in the same cycle as a second ovf[0] -> flag stays 1; clear alone -> irq=0 next cycle.
REQ-033 Write 0x17 twice consecutively -> count_reset[1] high for 2 cycles and count_reset[0] stays 0.
REQ-034 Read 0x08/0x09 with counter_val[15:0]=0xBEEF -> data_read is 0xEF then 0xBE, each 1 cycle after the read.
REQ-035 Assert rst_n=0 while upd_pending=1 -> all outputs 0; after release, ovf causes no commit.
